// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: FSM states, condition-code encodings,
// opcode map and small opcode-classification helpers.
package memory_stage_pkg;

  localparam int OPCODE_WIDTH = 8;

  typedef enum logic {
    MEMST_IDLE = 1'b0,
    MEMST_WAIT = 1'b1
  } memst_e;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = 8'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 8'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 8'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 8'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = 8'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = 8'h06;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW   = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 8'h18;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = 8'h19;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR  = 8'h1A;
  // Branch opcodes carry their NZP mask in the low three bits.
  localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = 8'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ   = 8'h22;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZP  = 8'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = 8'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNP  = 8'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ  = 8'h26;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = 8'h27;

  function automatic logic is_branch(input logic [OPCODE_WIDTH-1:0] op);
    return (op[OPCODE_WIDTH-1:3] == 5'b00100) && (op[2:0] != 3'b000);
  endfunction

  function automatic logic [2:0] branch_mask(input logic [OPCODE_WIDTH-1:0] op);
    return is_branch(op) ? op[2:0] : 3'b000;
  endfunction

  function automatic logic is_alu(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_AND) ||
           (op == OP_ANDI) || (op == OP_MOV) || (op == OP_MOVI);
  endfunction

  function automatic logic is_mem(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

  function automatic logic is_link(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_JSR) || (op == OP_JSRR);
  endfunction

  function automatic logic is_ctrl(input logic [OPCODE_WIDTH-1:0] op);
    return is_branch(op) || (op == OP_JMP) || is_link(op);
  endfunction

endpackage

// File: rtl/memory_stage_branch_resolve.sv
// Combinational branch decision: opcode NZP mask against current condition codes.
// Zero latency; no flow control.
module branch_resolve
  import memory_stage_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              cc,
  output logic                    taken
);

  always_comb begin
    taken = 1'b0;
    if (is_branch(opcode)) begin
      taken = |(branch_mask(opcode) & cc);
    end else if ((opcode == OP_JMP) || is_link(opcode)) begin
      taken = 1'b1;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: ALU writeback, LDW/STW over a req/ack port, CC register, branch redirect.
// Latency 1 edge (memory ops 1+N edges to ack); O_MemStall holds upstream while an access is outstanding.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int REG_WIDTH   = 16,
  parameter int DADDR_WIDTH = 13
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_LOCK,
  input  logic [REG_WIDTH-1:0]    I_ALUOut,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic                    I_FetchStall,
  input  logic                    I_DepStall,
  input  logic                    I_DMemAck,
  input  logic [REG_WIDTH-1:0]    I_DMemRData,
  output logic                    O_DMemReq,
  output logic                    O_DMemWe,
  output logic [DADDR_WIDTH-1:0]  O_DMemAddr,
  output logic [REG_WIDTH-1:0]    O_DMemWData,
  output logic                    O_LOCK,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic                    O_RegWEn,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic                    O_BranchTaken,
  output logic [REG_WIDTH-1:0]    O_BranchPC,
  output logic                    O_MemStall
);

  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
    if (v[REG_WIDTH-1]) return CC_N;
    if (v == '0)        return CC_Z;
    return CC_P;
  endfunction

  memst_e                  state_q, state_d;
  logic [2:0]              cc_q, cc_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [REG_WIDTH-1:0]    wdata_q, wdata_d;
  logic                    is_load_q, is_load_d;
  logic                    lock_q, lock_d;
  logic [OPCODE_WIDTH-1:0] opcode_q, opcode_d;
  logic [3:0]              dest_idx_q, dest_idx_d;
  logic [REG_WIDTH-1:0]    dest_value_q, dest_value_d;
  logic                    reg_wen_q, reg_wen_d;
  logic                    fetch_stall_q, fetch_stall_d;
  logic                    dep_stall_q, dep_stall_d;
  logic                    taken_q, taken_d;
  logic [REG_WIDTH-1:0]    branch_pc_q, branch_pc_d;
  logic                    br_taken;

  branch_resolve u_branch_resolve (
    .opcode (I_Opcode),
    .cc     (cc_q),
    .taken  (br_taken)
  );

  always_comb begin
    state_d       = state_q;
    cc_d          = cc_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    is_load_d     = is_load_q;
    lock_d        = I_LOCK;
    opcode_d      = opcode_q;
    dest_idx_d    = dest_idx_q;
    dest_value_d  = dest_value_q;
    fetch_stall_d = fetch_stall_q;
    dep_stall_d   = dep_stall_q;
    branch_pc_d   = branch_pc_q;
    // Commit/redirect are per-retirement pulses, so they fall whenever nothing retires.
    reg_wen_d     = 1'b0;
    taken_d       = 1'b0;

    if (I_LOCK) begin
      case (state_q)
        MEMST_IDLE: begin
          opcode_d      = I_Opcode;
          dest_idx_d    = I_DestRegIdx;
          fetch_stall_d = I_FetchStall;
          dep_stall_d   = I_DepStall;
          if (!(I_FetchStall || I_DepStall)) begin
            if (is_alu(I_Opcode)) begin
              dest_value_d = I_ALUOut;
              reg_wen_d    = 1'b1;
              cc_d         = cc_of(I_ALUOut);
            end else if (is_mem(I_Opcode)) begin
              req_d     = 1'b1;
              we_d      = (I_Opcode == OP_STW);
              addr_d    = I_ALUOut[DADDR_WIDTH+1:2];
              wdata_d   = I_DestValue;
              is_load_d = (I_Opcode == OP_LDW);
              state_d   = MEMST_WAIT;
            end else if (is_ctrl(I_Opcode)) begin
              taken_d     = br_taken;
              branch_pc_d = I_ALUOut;
              if (is_link(I_Opcode)) begin
                dest_value_d = I_DestValue;
                reg_wen_d    = 1'b1;
              end
            end
          end
        end
        MEMST_WAIT: begin
          if (I_DMemAck) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = MEMST_IDLE;
            if (is_load_q) begin
              dest_value_d = I_DMemRData;
              reg_wen_d    = 1'b1;
              cc_d         = cc_of(I_DMemRData);
            end
          end
        end
        default: state_d = MEMST_IDLE;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q       <= MEMST_IDLE;
      cc_q          <= CC_Z;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      is_load_q     <= 1'b0;
      lock_q        <= 1'b0;
      opcode_q      <= '0;
      dest_idx_q    <= '0;
      dest_value_q  <= '0;
      reg_wen_q     <= 1'b0;
      fetch_stall_q <= 1'b0;
      dep_stall_q   <= 1'b0;
      taken_q       <= 1'b0;
      branch_pc_q   <= '0;
    end else begin
      state_q       <= state_d;
      cc_q          <= cc_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      is_load_q     <= is_load_d;
      lock_q        <= lock_d;
      opcode_q      <= opcode_d;
      dest_idx_q    <= dest_idx_d;
      dest_value_q  <= dest_value_d;
      reg_wen_q     <= reg_wen_d;
      fetch_stall_q <= fetch_stall_d;
      dep_stall_q   <= dep_stall_d;
      taken_q       <= taken_d;
      branch_pc_q   <= branch_pc_d;
    end
  end

  assign O_DMemReq     = req_q;
  assign O_DMemWe      = we_q;
  assign O_DMemAddr    = addr_q;
  assign O_DMemWData   = wdata_q;
  assign O_LOCK        = lock_q;
  assign O_Opcode      = opcode_q;
  assign O_DestRegIdx  = dest_idx_q;
  assign O_DestValue   = dest_value_q;
  assign O_RegWEn      = reg_wen_q;
  assign O_FetchStall  = fetch_stall_q;
  assign O_DepStall    = dep_stall_q;
  assign O_BranchTaken = taken_q;
  assign O_BranchPC    = branch_pc_q;
  assign O_MemStall    = (state_q == MEMST_WAIT);

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: spec-level model compared every cycle, plus literal spot checks.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock = 1'b0;
  logic [15:0] alu = '0;
  logic [7:0]  opc = OP_NOP;
  logic [3:0]  idx = '0;
  logic [15:0] dv = '0;
  logic        fs = 1'b0, ds = 1'b0, ack = 1'b0;
  logic [15:0] rdata = '0;

  logic        o_req, o_we, o_lock, o_regwen, o_fs, o_ds, o_taken, o_stall;
  logic [12:0] o_addr;
  logic [15:0] o_wdata, o_dv, o_pc;
  logic [7:0]  o_opc;
  logic [3:0]  o_idx;

  int tests = 0;
  int fails = 0;

  memory_stage dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_ALUOut(alu), .I_Opcode(opc),
    .I_DestRegIdx(idx), .I_DestValue(dv), .I_FetchStall(fs), .I_DepStall(ds),
    .I_DMemAck(ack), .I_DMemRData(rdata),
    .O_DMemReq(o_req), .O_DMemWe(o_we), .O_DMemAddr(o_addr), .O_DMemWData(o_wdata),
    .O_LOCK(o_lock), .O_Opcode(o_opc), .O_DestRegIdx(o_idx), .O_DestValue(o_dv),
    .O_RegWEn(o_regwen), .O_FetchStall(o_fs), .O_DepStall(o_ds),
    .O_BranchTaken(o_taken), .O_BranchPC(o_pc), .O_MemStall(o_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: condition codes kept as three truths, memory access as a pending flag.
  logic        m_n, m_z, m_p, m_busy, m_busy_load;
  logic        m_lock, m_regwen, m_taken, m_req, m_we, m_fs, m_ds;
  logic [7:0]  m_opc;
  logic [3:0]  m_idx;
  logic [15:0] m_dv, m_pc, m_wdata;
  logic [12:0] m_addr;

  task automatic set_cc(input logic [15:0] v);
    m_n = ($signed(v) < 0);
    m_z = (v == 16'd0);
    m_p = ($signed(v) > 0);
  endtask

  task automatic redirect(input logic cond);
    m_taken = cond;
    m_pc    = alu;
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_z = 1; m_p = 0; m_busy = 0; m_busy_load = 0;
      m_lock = 0; m_regwen = 0; m_taken = 0; m_req = 0; m_we = 0; m_fs = 0; m_ds = 0;
      m_opc = 0; m_idx = 0; m_dv = 0; m_pc = 0; m_wdata = 0; m_addr = 0;
    end else begin
      m_lock = lock;
      m_regwen = 0;
      m_taken = 0;
      if (lock && m_busy) begin
        if (ack) begin
          m_busy = 0; m_req = 0; m_we = 0;
          if (m_busy_load) begin
            m_dv = rdata; m_regwen = 1; set_cc(rdata);
          end
        end
      end else if (lock) begin
        m_opc = opc; m_idx = idx; m_fs = fs; m_ds = ds;
        if (!(fs || ds)) begin
          case (opc)
            OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI: begin
              m_dv = alu; m_regwen = 1; set_cc(alu);
            end
            OP_LDW, OP_STW: begin
              m_busy = 1; m_busy_load = (opc == OP_LDW);
              m_req = 1; m_we = (opc == OP_STW);
              m_addr = 13'((alu / 4) % 8192);
              m_wdata = dv;
            end
            OP_BRN:   redirect(m_n);
            OP_BRZ:   redirect(m_z);
            OP_BRP:   redirect(m_p);
            OP_BRNZ:  redirect(m_n || m_z);
            OP_BRNP:  redirect(m_n || m_p);
            OP_BRZP:  redirect(m_z || m_p);
            OP_BRNZP, OP_JMP: redirect(1'b1);
            OP_JSR, OP_JSRR: begin
              redirect(1'b1); m_dv = dv; m_regwen = 1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      check("cmp_lock", o_lock, m_lock);
      check("cmp_regwen", o_regwen, m_regwen);
      check("cmp_taken", o_taken, m_taken);
      check("cmp_req", o_req, m_req);
      check("cmp_memstall", o_stall, m_busy);
      check("cmp_opcode", o_opc, m_opc);
      check("cmp_destidx", o_idx, m_idx);
      check("cmp_fstall", o_fs, m_fs);
      check("cmp_dstall", o_ds, m_ds);
      if (m_regwen) check("cmp_destvalue", o_dv, m_dv);
      if (m_taken)  check("cmp_branchpc", o_pc, m_pc);
      if (m_req) begin
        check("cmp_we", o_we, m_we);
        check("cmp_addr", o_addr, m_addr);
        check("cmp_wdata", o_wdata, m_wdata);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d,
                       input logic [3:0] i);
    opc = op; alu = a; dv = d; idx = i; fs = 0; ds = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_req", o_req, 0);
    check("rst_regwen", o_regwen, 0);
    check("rst_taken", o_taken, 0);
    check("rst_lock", o_lock, 0);
    check("rst_memstall", o_stall, 0);
    check("rst_destvalue", o_dv, 0);
    check("rst_addr", o_addr, 0);
    @(posedge clk); #1;
    rst = 0; lock = 1;

    // Reset leaves CC=Z: BRZ taken, BRN not.
    drive(OP_BRZ, 16'h0010, 0, 0); step();
    check("cc_rst_brz_taken", o_taken, 1);
    check("cc_rst_brz_pc", o_pc, 16'h0010);
    drive(OP_BRN, 16'h0020, 0, 0); step();
    check("cc_rst_brn_taken", o_taken, 0);

    // Negative ALU result then branch.
    drive(OP_ADDI, 16'hFFF0, 0, 4'd3); step();
    check("addi_regwen", o_regwen, 1);
    check("addi_value", o_dv, 16'hFFF0);
    drive(OP_BRN, 16'h0040, 0, 0); step();
    check("brn_taken", o_taken, 1);
    check("brn_pc", o_pc, 16'h0040);
    drive(OP_BRZ, 16'h0080, 0, 0); step();
    check("brz_not_taken", o_taken, 0);
    drive(OP_NOP, 16'h0000, 0, 0); step();
    check("taken_pulse", o_taken, 0);

    // Zero result sets Z.
    drive(OP_MOVI, 16'h0000, 0, 4'd1); step();
    drive(OP_BRZP, 16'h0050, 0, 0); step();
    check("movi0_brzp", o_taken, 1);

    // LDW with acknowledge three edges after issue; bundle during the wait is ignored.
    drive(OP_LDW, 16'h0008, 0, 4'd5); step();
    check("ldw_req", o_req, 1);
    check("ldw_we", o_we, 0);
    check("ldw_addr", o_addr, 13'd2);
    check("ldw_stall1", o_stall, 1);
    drive(OP_ADDI, 16'h5555, 0, 4'd9); step();
    check("ldw_stall2", o_stall, 1);
    check("ldw_wait_regwen", o_regwen, 0);
    step();
    check("ldw_stall3", o_stall, 1);
    check("ldw_req_held", o_req, 1);
    ack = 1; rdata = 16'h1234; step();
    ack = 0; drive(OP_NOP, 0, 0, 0);
    check("ldw_done_stall", o_stall, 0);
    check("ldw_done_req", o_req, 0);
    check("ldw_regwen", o_regwen, 1);
    check("ldw_value", o_dv, 16'h1234);
    check("ldw_idx", o_idx, 4'd5);
    step();
    check("ldw_regwen_pulse", o_regwen, 0);
    drive(OP_BRP, 16'h0100, 0, 0); step();
    check("ldw_cc_p", o_taken, 1);
    drive(OP_BRNZ, 16'h0104, 0, 0); step();
    check("ldw_cc_not_nz", o_taken, 0);

    // STW with single-edge acknowledge; CC stays P.
    drive(OP_STW, 16'h000C, 16'hBEEF, 4'd2); step();
    check("stw_req", o_req, 1);
    check("stw_we", o_we, 1);
    check("stw_addr", o_addr, 13'd3);
    check("stw_wdata", o_wdata, 16'hBEEF);
    drive(OP_NOP, 0, 0, 0);
    ack = 1; step();
    ack = 0;
    check("stw_done_req", o_req, 0);
    check("stw_regwen", o_regwen, 0);
    drive(OP_BRP, 16'h0110, 0, 0); step();
    check("stw_cc_kept", o_taken, 1);

    // Address wraps and ignores the byte offset; negative load sets N.
    drive(OP_LDW, 16'h8005, 0, 4'd7); step();
    check("wrap_addr", o_addr, 13'd1);
    drive(OP_NOP, 0, 0, 0);
    ack = 1; rdata = 16'h8000; step();
    ack = 0;
    check("wrap_value", o_dv, 16'h8000);
    drive(OP_BRN, 16'h0120, 0, 0); step();
    check("ldw_cc_n", o_taken, 1);

    // Bubble: no request, flags forwarded.
    drive(OP_LDW, 16'h0010, 0, 4'd4); ds = 1; step();
    check("bubble_req", o_req, 0);
    check("bubble_regwen", o_regwen, 0);
    check("bubble_depstall", o_ds, 1);
    check("bubble_stall", o_stall, 0);
    drive(OP_ADDI, 16'h0001, 0, 4'd4); fs = 1; step();
    check("bubble_fstall", o_fs, 1);
    check("bubble_alu_regwen", o_regwen, 0);

    // Ack while idle is ignored.
    drive(OP_NOP, 0, 0, 0); ack = 1; rdata = 16'h0000; step();
    ack = 0;
    check("idle_ack_regwen", o_regwen, 0);
    check("idle_ack_stall", o_stall, 0);

    // JSR link.
    drive(OP_JSR, 16'h0200, 16'h0104, 4'd7); step();
    check("jsr_taken", o_taken, 1);
    check("jsr_pc", o_pc, 16'h0200);
    check("jsr_value", o_dv, 16'h0104);
    check("jsr_regwen", o_regwen, 1);

    // Lock low: nothing retires, CC untouched (still N from the load).
    drive(OP_ADDI, 16'h0001, 0, 4'd1); lock = 0; step();
    check("nolock_lock", o_lock, 0);
    check("nolock_regwen", o_regwen, 0);
    lock = 1; drive(OP_BRN, 16'h0130, 0, 0); step();
    check("nolock_cc_kept", o_taken, 1);

    // Reset mid-access aborts the request immediately.
    drive(OP_LDW, 16'h0040, 0, 4'd2); step();
    check("abort_req_before", o_req, 1);
    drive(OP_NOP, 0, 0, 0);
    rst = 1; #1;
    check("abort_req", o_req, 0);
    check("abort_stall", o_stall, 0);
    step();
    rst = 0;
    drive(OP_BRZ, 16'h0300, 0, 0); step();
    check("abort_cc_z", o_taken, 1);
    drive(OP_NOP, 0, 0, 0); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
